display_scanner: RTL

- Time-multiplexes a packed hex value across a common-anode multi-digit seven-segment display.
- Each scan slot presents one 4-bit nibble on `code`, which feeds the existing hex-to-segment pattern decoder, and drives the matching active-low anode select.
- Holds the data in a double buffer so a new value is only shown at a frame boundary, which prevents tearing.
- Sits between the datapath or debug registers and the segment decoder.

---
 rtl/display_scanner.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/display_scanner.sv
// display_scanner: time-multiplexes a packed hex value across a common-anode
// seven-segment display; one nibble per scan slot, double-buffered at frame wrap.
// Latency: code/an/frame_done are registered, 1 cycle behind the scan index.
// Backpressure: none; load is accepted every cycle, en=0 blanks and freezes the scan.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   en           scan enable (low blanks the display, holds prescaler/index/code)
//   data, load   value to display (nibble k -> digit k, digit 0 rightmost) and its capture strobe
//   code         nibble of the digit currently lit, to the hex-to-segment decoder
//   an           active-low anode selects, one-hot-low while a digit is lit
//   frame_done   one-cycle pulse after the scan wraps from the last digit to digit 0
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading-zero digits
// (digit 0 always stays lit).

module display_scanner #(
   parameter int CLK_DIV = 100000,
   parameter int DIGITS  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  load,
   output logic [3:0]            code,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   pending_q, pending_d;
   logic                  pend_vld_q, pend_vld_d;
   logic [4*DIGITS-1:0]   shadow_q, shadow_d;
   logic [3:0]            code_q, code_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  frame_done_q, frame_done_d;

   logic                  tick;
   logic                  wrap;
   logic [3:0]            cur_nib;
   logic                  blank_cur;

`ifdef LEADING_ZERO_BLANK_EN
   // zero_from[k] is set when nibbles k..DIGITS-1 of the shown value are all zero.
   logic [DIGITS-1:0]     zero_from;
   logic                  zero_acc;

   always_comb begin
      zero_acc  = 1'b1;
      zero_from = '0;
      blank_cur = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_acc     = zero_acc && (shadow_q[4*k +: 4] == 4'h0);
         zero_from[k] = zero_acc;
      end
      // Digit 0 is excluded so a value of zero still shows a single "0".
      for (int k = 1; k < DIGITS; k++) begin
         if ((idx_q == IW'(k)) && zero_from[k]) begin
            blank_cur = 1'b1;
         end
      end
   end
`else
   assign blank_cur = 1'b0;
`endif

   always_comb begin
      tick = en && (presc_q == PRESC_MAX);
      wrap = tick && (idx_q == IDX_MAX);

      presc_d = presc_q;
      if (en) begin
         presc_d = tick ? '0 : presc_q + PW'(1);
      end

      idx_d = idx_q;
      if (tick) begin
         idx_d = wrap ? '0 : idx_q + IW'(1);
      end

      // Transfer first, then capture: a load landing on the wrap tick sends the
      // old pending value to the display and keeps the new one pending.
      pending_d  = pending_q;
      pend_vld_d = pend_vld_q;
      shadow_d   = shadow_q;
      if (wrap && pend_vld_q) begin
         shadow_d   = pending_q;
         pend_vld_d = 1'b0;
      end
      if (load) begin
         pending_d  = data;
         pend_vld_d = 1'b1;
      end

      frame_done_d = wrap;

      cur_nib = 4'h0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx_q == IW'(k)) begin
            cur_nib = shadow_q[4*k +: 4];
         end
      end

      // Disabled: blank all anodes but keep the last code so the decoder input is stable.
      code_d = code_q;
      an_d   = '1;
      if (en) begin
         code_d = cur_nib;
         for (int k = 0; k < DIGITS; k++) begin
            an_d[k] = (idx_q != IW'(k));
         end
         if (blank_cur) begin
            an_d = '1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         pending_q    <= '0;
         pend_vld_q   <= 1'b0;
         shadow_q     <= '0;
         code_q       <= 4'h0;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         pend_vld_q   <= pend_vld_d;
         shadow_q     <= shadow_d;
         code_q       <= code_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign code       = code_q;
   assign an         = an_q;
   assign frame_done = frame_done_q;

endmodule
